rally_referee: RTL and testbench
================================

// Module: rally_referee
// PURPOSE
//  Receiving end of the ball-position interface. Consumes the 16-bit one-hot
//  ball vector and its step strobe, plus debounced single-cycle paddle pulses.
//  Judges hits, misses and faults, then asks the ball mover to reverse.
//  Keeps score and sequences serve / rally / point / game-over.
// PARAMETERS
//  HIT_WIN     3   hit window depth in LED positions at each end (1..8)
//  WIN_SCORE   7   points needed to win (1..15)
//  POINT_HOLD  8   clk cycles spent in POINT before returning to IDLE (>=1)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  ball       in   16  one-hot ball position; bit 0 = left end, bit 15 = right end
//  ball_step  in   1   1-cycle pulse, ball vector advances this cycle
//  serve      in   1   1-cycle debounced serve pulse
//  btn_l      in   1   1-cycle debounced left paddle pulse
//  btn_r      in   1   1-cycle debounced right paddle pulse
//  reverse    out  1   1-cycle pulse, ball mover must reverse direction
//  rally_dir  out  1   1 = ball travels toward bit 15, 0 = toward bit 0
//  point_l    out  1   1-cycle pulse, left player scored
//  point_r    out  1   1-cycle pulse, right player scored
//  score_l    out  4   left score
//  score_r    out  4   right score
//  game_over  out  1   level; a score has reached WIN_SCORE
//  ball_idx   out  4   registered binary index of ball (valid vectors only)
//  ball_err   out  1   sticky: non-one-hot vector seen during a rally
// BEHAVIOUR
//  Reset values
//   - All outputs 0.
//   - State IDLE; server = left.
//  Output timing
//   - All outputs are registered.
//   - Judgement uses the current-cycle ball/ball_idx and inputs; reverse and
//     point_* go high on the next cycle.
//  Ball decode
//   - valid = exactly one bit set.
//   - ball_idx updates on valid vectors only; it holds on invalid ones.
//  States and transitions
//   - IDLE: on serve, if !game_over, go to RALLY_R when server = left,
//     else RALLY_L. No reverse is issued on serve.
//   - RALLY_R (rally_dir = 1), judged only on btn_r; btn_l is ignored.
//     - Hit: btn_r & valid & idx >= 16-HIT_WIN. Pulse reverse; go to RALLY_L.
//     - Fault: btn_r outside window, or btn_r while invalid. Point to left.
//     - Miss: ball_step & valid & idx == 15 with no btn_r. Point to left.
//   - RALLY_L mirrors RALLY_R:
//     - Judged on btn_l; btn_r is ignored.
//     - Hit window idx < HIT_WIN.
//     - Miss at idx == 0 on ball_step.
//     - Fault or miss gives the point to right.
//   - POINT: hold POINT_HOLD cycles, then go to IDLE.
//   - serve is ignored outside IDLE.
//  Scoring
//   - On entering POINT: pulse point_x, increment score_x.
//   - Server for the next point is the player who lost the point.
//   - A score that reaches WIN_SCORE sets game_over and saturates there.
//   - game_over stays set until reset; IDLE then ignores serve.
//  Simultaneous events
//   - Hit and miss in the same cycle (btn_r & ball_step at idx 15):
//     the hit wins.
//   - Both buttons pressed: only the receiving player's button counts.
//  Invalid ball vector (zero or multi-hot) during a rally
//   - Set ball_err.
//   - A miss is not judged.
//   - A receiving press is a fault.
//  Reset mid-rally or mid-POINT
//   - Everything returns to reset values on the next edge.
//   - No pulse is emitted.
// TESTING
//  1. Reset, serve, ball at idx 14, btn_r
//     -> reverse high 1 cycle later; rally_dir 1->0; scores 0/0.
//  2. RALLY_R, ball at idx 12 (HIT_WIN = 3), btn_r
//     -> point_l pulse; score_l = 1; server = right;
//        IDLE after 8 cycles in POINT.
//  3. RALLY_R, ball at idx 15, ball_step with no press
//     -> point_l; same cycle with btn_r -> reverse, no point.
//  4. RALLY_L, btn_r and btn_l together at idx 1
//     -> hit (reverse), btn_r ignored.
//  5. Left wins 7 points
//     -> game_over = 1, score_l = 7; later serve ignored; reset clears all.
//  6. ball = 16'h0003 in RALLY_R, then btn_r
//     -> ball_err set, ball_idx held, point_l; reset mid-POINT clears outputs.

Source files
------------

// File: rtl/rally_referee.sv
// Rally referee: decodes the one-hot ball, judges paddle hits, misses and faults,
// keeps score and sequences serve / rally / point / game-over. All outputs registered.
module rally_referee #(
   parameter int HIT_WIN    = 3,
   parameter int WIN_SCORE  = 7,
   parameter int POINT_HOLD = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ball,
   input  logic        ball_step,
   input  logic        serve,
   input  logic        btn_l,
   input  logic        btn_r,
   output logic        reverse,
   output logic        rally_dir,
   output logic        point_l,
   output logic        point_r,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        game_over,
   output logic [3:0]  ball_idx,
   output logic        ball_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RALLY_R = 2'd1,
      RALLY_L = 2'd2,
      POINT   = 2'd3
   } state_t;

   localparam int              CW        = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
   localparam logic [CW-1:0]   HOLD_LAST = CW'(POINT_HOLD - 1);
   localparam logic [3:0]      R_WIN_LO  = 4'(16 - HIT_WIN);
   localparam logic [3:0]      L_WIN_HI  = 4'(HIT_WIN);
   localparam logic [3:0]      WIN       = 4'(WIN_SCORE);

   state_t        state_q, state_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          server_q, server_d;          // 0 = left serves
   logic          reverse_q, reverse_d;
   logic          rally_dir_q, rally_dir_d;
   logic          point_l_q, point_l_d;
   logic          point_r_q, point_r_d;
   logic [3:0]    score_l_q, score_l_d;
   logic [3:0]    score_r_q, score_r_d;
   logic          game_over_q, game_over_d;
   logic [3:0]    ball_idx_q, ball_idx_d;
   logic          ball_err_q, ball_err_d;

   logic          valid_s;
   logic [3:0]    idx_s;
   logic          hit_s, fault_s, miss_s;
   logic          award_l_s, award_r_s;
   logic          in_rally_s;

   // OR-encode is exact for one-hot vectors; other vectors are flagged invalid
   always_comb begin
      valid_s = (ball != 16'd0) && ((ball & (ball - 16'd1)) == 16'd0);
      idx_s   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         idx_s = idx_s | ({4{ball[i]}} & 4'(i));
      end
   end

   always_comb begin
      hit_s   = 1'b0;
      fault_s = 1'b0;
      miss_s  = 1'b0;
      case (state_q)
         RALLY_R: begin
            hit_s   = btn_r & valid_s & (idx_s >= R_WIN_LO);
            fault_s = btn_r & ~hit_s;
            miss_s  = ~btn_r & ball_step & valid_s & (idx_s == 4'd15);
         end
         RALLY_L: begin
            hit_s   = btn_l & valid_s & (idx_s < L_WIN_HI);
            fault_s = btn_l & ~hit_s;
            miss_s  = ~btn_l & ball_step & valid_s & (idx_s == 4'd0);
         end
         default: begin
            hit_s   = 1'b0;
            fault_s = 1'b0;
            miss_s  = 1'b0;
         end
      endcase
      in_rally_s = (state_q == RALLY_R) || (state_q == RALLY_L);
      award_l_s  = (state_q == RALLY_R) & (fault_s | miss_s);
      award_r_s  = (state_q == RALLY_L) & (fault_s | miss_s);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         server_q    <= 1'b0;
         reverse_q   <= 1'b0;
         rally_dir_q <= 1'b0;
         point_l_q   <= 1'b0;
         point_r_q   <= 1'b0;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         game_over_q <= 1'b0;
         ball_idx_q  <= 4'd0;
         ball_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         server_q    <= server_d;
         reverse_q   <= reverse_d;
         rally_dir_q <= rally_dir_d;
         point_l_q   <= point_l_d;
         point_r_q   <= point_r_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         game_over_q <= game_over_d;
         ball_idx_q  <= ball_idx_d;
         ball_err_q  <= ball_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (serve && !game_over_q) begin
               state_d = server_q ? RALLY_L : RALLY_R;
            end else begin
               state_d = IDLE;
            end
         end
         RALLY_R, RALLY_L: begin
            if (hit_s) begin
               state_d = (state_q == RALLY_R) ? RALLY_L : RALLY_R;
            end else if (fault_s || miss_s) begin
               state_d = POINT;
               hold_d  = HOLD_LAST;
            end else begin
               state_d = state_q;
            end
         end
         POINT: begin
            if (hold_q == '0) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // Score saturates at WIN; the loser of a point serves the next one
   always_comb begin
      reverse_d   = hit_s;
      point_l_d   = award_l_s;
      point_r_d   = award_r_s;
      rally_dir_d = (state_d == RALLY_R);
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      server_d    = server_q;
      if (award_l_s) begin
         server_d = 1'b1;
         if (score_l_q != WIN) begin
            score_l_d = score_l_q + 4'd1;
         end else begin
            score_l_d = score_l_q;
         end
      end else if (award_r_s) begin
         server_d = 1'b0;
         if (score_r_q != WIN) begin
            score_r_d = score_r_q + 4'd1;
         end else begin
            score_r_d = score_r_q;
         end
      end else begin
         server_d = server_q;
      end
      game_over_d = game_over_q | (score_l_d == WIN) | (score_r_d == WIN);
      ball_idx_d  = valid_s ? idx_s : ball_idx_q;
      ball_err_d  = ball_err_q | (in_rally_s & ~valid_s);
   end

   assign reverse   = reverse_q;
   assign rally_dir = rally_dir_q;
   assign point_l   = point_l_q;
   assign point_r   = point_r_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign game_over = game_over_q;
   assign ball_idx  = ball_idx_q;
   assign ball_err  = ball_err_q;

endmodule

// File: tb/tb_rally_referee.sv
// Scoreboard bench for rally_referee: a behavioural model pushes the expected
// output word for each driven cycle; it is popped and compared after the edge.
module tb_rally_referee;

   localparam int HIT_WIN    = 3;
   localparam int WIN_SCORE  = 7;
   localparam int POINT_HOLD = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] ball = 16'h0001;
   logic        ball_step = 1'b0, serve = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
   logic        reverse, rally_dir, point_l, point_r, game_over, ball_err;
   logic [3:0]  score_l, score_r, ball_idx;

   int total = 0;
   int bad   = 0;
   logic [17:0] exp_q[$];

   // model state: 0 idle, 1 rally toward right, 2 rally toward left, 3 point
   int m_state = 0, m_sl = 0, m_sr = 0, m_idx = 0, m_cnt = 0;
   bit m_server = 1'b0, m_go = 1'b0, m_err = 1'b0;

   rally_referee #(.HIT_WIN(HIT_WIN), .WIN_SCORE(WIN_SCORE), .POINT_HOLD(POINT_HOLD)) dut (
      .clk(clk), .reset(reset), .ball(ball), .ball_step(ball_step), .serve(serve),
      .btn_l(btn_l), .btn_r(btn_r), .reverse(reverse), .rally_dir(rally_dir),
      .point_l(point_l), .point_r(point_r), .score_l(score_l), .score_r(score_r),
      .game_over(game_over), .ball_idx(ball_idx), .ball_err(ball_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // word layout: rev dir pl pr score_l score_r go idx err
   function automatic logic [17:0] dut_word();
      return {reverse, rally_dir, point_l, point_r, score_l, score_r, game_over, ball_idx, ball_err};
   endfunction

   task automatic cyc(input string tag, input logic [15:0] b, input logic st, input logic sv,
                      input logic bl, input logic br, input logic rs);
      bit v, rev, pl, pr;
      int idx;
      ball = b; ball_step = st; serve = sv; btn_l = bl; btn_r = br; reset = rs;
      v = ($countones(b) == 1);
      idx = 0;
      for (int i = 0; i < 16; i++) if (b[i]) idx = i;
      rev = 0; pl = 0; pr = 0;
      if (rs) begin
         m_state = 0; m_sl = 0; m_sr = 0; m_idx = 0; m_cnt = 0;
         m_server = 0; m_go = 0; m_err = 0;
      end else begin
         if ((m_state == 1 || m_state == 2) && !v) m_err = 1;
         case (m_state)
            0: if (sv && !m_go) m_state = m_server ? 2 : 1;
            1: if (br) begin
                  if (v && idx >= 16 - HIT_WIN) begin rev = 1; m_state = 2; end
                  else pl = 1;
               end else if (st && v && idx == 15) pl = 1;
            2: if (bl) begin
                  if (v && idx < HIT_WIN) begin rev = 1; m_state = 1; end
                  else pr = 1;
               end else if (st && v && idx == 0) pr = 1;
            3: if (m_cnt == 0) m_state = 0; else m_cnt--;
            default: m_state = 0;
         endcase
         if (pl) begin
            if (m_sl < WIN_SCORE) m_sl++;
            m_server = 1; m_state = 3; m_cnt = POINT_HOLD - 1;
         end
         if (pr) begin
            if (m_sr < WIN_SCORE) m_sr++;
            m_server = 0; m_state = 3; m_cnt = POINT_HOLD - 1;
         end
         if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) m_go = 1;
         if (v) m_idx = idx;
      end
      exp_q.push_back({rev, (m_state == 1), pl, pr, 4'(m_sl), 4'(m_sr), m_go, 4'(m_idx), m_err});
      @(posedge clk);
      #1;
      check(tag, 32'(dut_word()), 32'(exp_q.pop_front()));
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cyc(tag, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc("reset0", 16'h0001, 0, 0, 0, 0, 1);
      cyc("reset1", 16'h0001, 0, 0, 0, 0, 1);
      check("reset_all_zero", 32'(dut_word()), 32'd0);
      idle("idle", 2);

      // serve from left, hit at idx 14
      cyc("serve1", 16'h0010, 0, 1, 0, 0, 0);
      check("dir_after_serve", 32'(rally_dir), 32'd1);
      cyc("hit14", 16'h4000, 0, 0, 0, 1, 0);
      check("hit14_reverse", 32'(reverse), 32'd1);
      check("hit14_dir", 32'(rally_dir), 32'd0);
      // both buttons at idx 1 while ball heads left: left hit counts
      cyc("both_idx1", 16'h0002, 1, 0, 1, 1, 0);
      check("both_reverse", 32'(reverse), 32'd1);
      // early press at idx 12 is a fault
      cyc("fault12", 16'h1000, 0, 0, 0, 1, 0);
      check("fault12_score", 32'({point_l, score_l}), 32'h11);
      idle("point_hold", POINT_HOLD);
      // server is now right: rally leftward, miss at idx 0
      cyc("serve2", 16'h0080, 0, 1, 0, 0, 0);
      check("serve2_dir", 32'(rally_dir), 32'd0);
      cyc("btn_r_ignored", 16'h0001, 0, 0, 0, 1, 0);
      cyc("miss0", 16'h0001, 1, 0, 0, 0, 0);
      check("miss0_point_r", 32'({point_r, score_r}), 32'h11);
      idle("point_hold", POINT_HOLD);
      // left serves: hit and step together at idx 15 -> hit wins
      cyc("serve3", 16'h0080, 0, 1, 0, 0, 0);
      cyc("hit_and_step15", 16'h8000, 1, 0, 0, 1, 0);
      cyc("late_fault_l", 16'h0020, 0, 0, 1, 0, 0);
      idle("point_hold", POINT_HOLD);
      cyc("serve4", 16'h0080, 0, 1, 0, 0, 0);
      cyc("miss15", 16'h8000, 1, 0, 0, 0, 0);
      check("miss15_point_l", 32'({point_l, score_l}), 32'h12);
      idle("point_hold", POINT_HOLD);
      // right serves, left returns; then invalid vectors during rally
      cyc("serve5", 16'h0004, 0, 1, 0, 0, 0);
      cyc("hit0", 16'h0001, 0, 0, 1, 0, 0);
      cyc("multi_hot", 16'h0003, 1, 0, 0, 0, 0);
      check("err_idx_held", 32'({ball_err, ball_idx}), 32'h10);
      cyc("invalid_press", 16'h0003, 0, 0, 0, 1, 0);
      check("invalid_press_point", 32'(point_l), 32'd1);
      idle("point_hold", 3);
      cyc("reset_mid_point", 16'h0001, 0, 0, 0, 0, 1);
      check("reset_clears", 32'(dut_word()), 32'd0);
      idle("after_reset", 2);
      // reset mid-rally
      cyc("serve6", 16'h0008, 0, 1, 0, 0, 0);
      cyc("reset_mid_rally", 16'h0008, 0, 0, 0, 0, 1);
      idle("after_reset", 2);

      // left wins every point until game over
      for (int p = 0; p < WIN_SCORE; p++) begin
         cyc("g_serve", 16'h0100, 0, 1, 0, 0, 0);
         if (m_state == 2) cyc("g_hit_l", 16'h0001, 0, 0, 1, 0, 0);
         cyc("g_miss_r", 16'h8000, 1, 0, 0, 0, 0);
         idle("g_hold", POINT_HOLD);
      end
      check("game_over_score", 32'({game_over, score_l}), 32'h17);
      cyc("serve_ignored", 16'h0100, 0, 1, 0, 0, 0);
      check("serve_ignored_dir", 32'(rally_dir), 32'd0);
      idle("game_over_idle", 3);
      cyc("final_reset", 16'h0001, 0, 0, 0, 0, 1);
      check("final_reset_zero", 32'(dut_word()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
